// File: rtl/stream_vadd_pkg.sv
// stream_vadd_pkg
//   Shared types and helpers for the stream_vadd_n vector adder.
//   - state_t     : controller FSM encoding
//   - count_t     : element counter / expected length type
//   - eot_bit()   : bit index of the EoT flag in a stream word
//   - word_width(): stream word width for a given payload width
package stream_vadd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLOSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int COUNT_WIDTH = 64;

  typedef logic [COUNT_WIDTH-1:0] count_t;

  // The EoT flag sits directly above the payload.
  function automatic int eot_bit(input int width);
    return width;
  endfunction

  function automatic int word_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/stream_vadd_n_if.sv
// stream_vadd_n_if
//   Stream bundle for stream_vadd_n: NUM_IN packed input FIFO heads with
//   per-stream valid/pop, plus one output FIFO write port.
//   master : the adder side (pops inputs, pushes output)
//   slave  : the environment side (presents inputs, accepts output)
interface stream_vadd_n_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 2
);
  logic [NUM_IN*(DATA_WIDTH+1)-1:0] in_dout;
  logic [NUM_IN-1:0]                in_empty_n;
  logic [NUM_IN-1:0]                in_read;
  logic [DATA_WIDTH:0]              out_din;
  logic                             out_full_n;
  logic                             out_write;

  modport master (
    input  in_dout, in_empty_n, out_full_n,
    output in_read, out_din, out_write
  );

  modport slave (
    output in_dout, in_empty_n, out_full_n,
    input  in_read, out_din, out_write
  );
endinterface

// File: rtl/stream_vadd_ofifo.sv
// stream_vadd_ofifo
//   DEPTH-entry register FIFO used as the adder's output buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write port (a push while full is taken only with a pop)
//   pop, dout  : read port, dout is the current head
//   full, empty: occupancy flags, both derived from registered pointers
module stream_vadd_ofifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/stream_vadd_n.sv
// stream_vadd_n
//   NUM_IN-input vector adder on FIFO streams with end-of-transfer tokens,
//   run as a leaf task under ap_start/ap_done control.
//   ap_clk, ap_rst_n        : clock, asynchronous active-low reset
//   ap_start                : level start request, held until ap_ready
//   ap_done/ap_ready/ap_idle: task handshake (done/ready pulse one cycle)
//   n                       : expected element count, latched at start
//   elem_count              : data beats emitted this run
//   err_eot                 : sticky, EoT seen on only some lanes of a beat
//   err_len                 : sticky, elem_count != n at close
//   strm                    : input heads/pops and output write port
//
// state | meaning
// IDLE  | waiting for ap_start
// RUN   | summing beats until every lane presents EoT
// CLOSE | close token queued, waiting for the output buffer to drain
// DONE  | one-cycle ap_done/ap_ready pulse
module stream_vadd_n
  import stream_vadd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 2,
  parameter int OUT_DEPTH  = 4,
  parameter int SATURATE   = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  input  count_t            n,
  output count_t            elem_count,
  output logic              err_eot,
  output logic              err_len,
  stream_vadd_n_if.master   strm
);
  localparam int WW = word_width(DATA_WIDTH);
  localparam int SW = DATA_WIDTH + $clog2(NUM_IN);

  state_t                state, state_nxt;
  count_t                n_q;
  logic [DATA_WIDTH-1:0] lane_data [NUM_IN];
  logic [NUM_IN-1:0]     lane_eot;
  logic [SW-1:0]         sum_full;
  logic [DATA_WIDTH-1:0] sum_out;
  logic [NUM_IN-1:0]     in_read_c;
  logic                  push, fifo_pop, fifo_full, fifo_empty, beat_ok;
  logic [WW-1:0]         push_word, fifo_dout;
  logic                  cnt_inc, eot_err_set, len_chk, start_take;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    assign lane_data[g] = strm.in_dout[g*WW +: DATA_WIDTH];
    assign lane_eot[g]  = strm.in_dout[g*WW + eot_bit(DATA_WIDTH)];
  end

  // Wide enough that the sum of all lanes never overflows before clamping.
  always_comb begin
    sum_full = '0;
    for (int i = 0; i < NUM_IN; i++) sum_full = sum_full + SW'(lane_data[i]);
  end

  assign sum_out = (SATURATE != 0 && |sum_full[SW-1:DATA_WIDTH]) ?
                   {DATA_WIDTH{1'b1}} : sum_full[DATA_WIDTH-1:0];

  // A beat may fill the last slot only if the head leaves the same cycle.
  assign fifo_pop = !fifo_empty && strm.out_full_n;
  assign beat_ok  = (state == ST_RUN) && (&strm.in_empty_n) && (!fifo_full || fifo_pop);

  always_comb begin
    state_nxt   = state;
    in_read_c   = '0;
    push        = 1'b0;
    push_word   = '0;
    cnt_inc     = 1'b0;
    eot_err_set = 1'b0;
    len_chk     = 1'b0;
    start_take  = 1'b0;
    ap_done     = 1'b0;
    ap_ready    = 1'b0;
    ap_idle     = 1'b0;
    case (state)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          start_take = 1'b1;
          state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (beat_ok) begin
          if (lane_eot == '0) begin
            in_read_c = '1;
            push      = 1'b1;
            push_word = {1'b0, sum_out};
            cnt_inc   = 1'b1;
          end else if (&lane_eot) begin
            in_read_c = '1;
            push      = 1'b1;
            push_word = {1'b1, {DATA_WIDTH{1'b0}}};
            state_nxt = ST_CLOSE;
          end else begin
            // Drain the lanes still carrying data; EoT lanes wait for the rest.
            in_read_c   = ~lane_eot;
            eot_err_set = 1'b1;
          end
        end
      end
      ST_CLOSE: begin
        if (fifo_empty) begin
          len_chk   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        if (ap_start) begin
          start_take = 1'b1;
          state_nxt  = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= ST_IDLE;
      n_q        <= '0;
      elem_count <= '0;
      err_eot    <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_take) begin
        n_q        <= n;
        elem_count <= '0;
        err_eot    <= 1'b0;
        err_len    <= 1'b0;
      end else begin
        if (cnt_inc)                       elem_count <= elem_count + count_t'(1);
        if (eot_err_set)                   err_eot    <= 1'b1;
        if (len_chk && (elem_count != n_q)) err_len   <= 1'b1;
      end
    end
  end

  stream_vadd_ofifo #(
    .WIDTH (WW),
    .DEPTH (OUT_DEPTH)
  ) u_ofifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (push),
    .din   (push_word),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign strm.in_read   = in_read_c;
  assign strm.out_write = fifo_pop;
  assign strm.out_din   = fifo_dout;

endmodule

// File: tb/tb_stream_vadd_n.sv
// tb_stream_vadd_n
//   Directed bench: a 2-lane 32-bit instance fed from per-lane word queues,
//   plus two 4-lane 8-bit instances (saturating and wrapping) driven directly.
module tb_stream_vadd_n;
  localparam logic [32:0] EOT33 = {1'b1, 32'd0};

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  int n_assert = 0;
  int n_fail   = 0;

  stream_vadd_n_if #(.DATA_WIDTH(32), .NUM_IN(2)) aif ();
  stream_vadd_n_if #(.DATA_WIDTH(8),  .NUM_IN(4)) bif ();
  stream_vadd_n_if #(.DATA_WIDTH(8),  .NUM_IN(4)) cif ();

  logic        a_start, a_done, a_ready, a_idle, a_err_eot, a_err_len;
  logic [63:0] n_a, a_elem;
  logic        b_start, b_done, b_ready, b_idle, b_err_eot, b_err_len;
  logic [63:0] n_b, b_elem;
  logic        c_done, c_ready, c_idle, c_err_eot, c_err_len;
  logic [63:0] c_elem;

  assign cif.in_dout    = bif.in_dout;
  assign cif.in_empty_n = bif.in_empty_n;
  assign cif.out_full_n = bif.out_full_n;

  stream_vadd_n #(.DATA_WIDTH(32), .NUM_IN(2), .OUT_DEPTH(4), .SATURATE(0)) u_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(a_start), .ap_done(a_done),
    .ap_ready(a_ready), .ap_idle(a_idle), .n(n_a), .elem_count(a_elem),
    .err_eot(a_err_eot), .err_len(a_err_len), .strm(aif));

  stream_vadd_n #(.DATA_WIDTH(8), .NUM_IN(4), .OUT_DEPTH(4), .SATURATE(1)) u_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(b_start), .ap_done(b_done),
    .ap_ready(b_ready), .ap_idle(b_idle), .n(n_b), .elem_count(b_elem),
    .err_eot(b_err_eot), .err_len(b_err_len), .strm(bif));

  stream_vadd_n #(.DATA_WIDTH(8), .NUM_IN(4), .OUT_DEPTH(4), .SATURATE(0)) u_c (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(b_start), .ap_done(c_done),
    .ap_ready(c_ready), .ap_idle(c_idle), .n(n_b), .elem_count(c_elem),
    .err_eot(c_err_eot), .err_len(c_err_len), .strm(cif));

  // Input queues for instance A and capture of its accepted output words.
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] cap[$];
  logic [32:0] exp_q[$];

  always @(posedge ap_clk) begin
    if (aif.in_read[0] && qa.size() > 0) void'(qa.pop_front());
    if (aif.in_read[1] && qb.size() > 0) void'(qb.pop_front());
    if (aif.out_write) cap.push_back(aif.out_din);
    #1;
    aif.in_empty_n = {qb.size() != 0, qa.size() != 0};
    aif.in_dout    = {(qb.size() != 0) ? qb[0] : 33'd0, (qa.size() != 0) ? qa[0] : 33'd0};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cap(input string tag);
    check({tag, " count"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s word%0d", tag, i), (i < cap.size()) ? 64'(cap[i]) : 64'hx, 64'(exp_q[i]));
  endtask

  task automatic start_a(input logic [63:0] nv);
    @(posedge ap_clk); #2;
    n_a = nv; a_start = 1'b1;
    @(posedge ap_clk); #2;
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 400 && seen == 0; i++) begin
      @(posedge ap_clk); #2;
      if (a_done === 1'b1) seen = 1;
    end
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " ready with done"}, 64'(a_ready), 64'd1);
    @(posedge ap_clk); #2;
    check({tag, " done one cycle"}, 64'(a_done), 64'd0);
    check({tag, " idle after done"}, 64'(a_idle), 64'd1);
  endtask

  task automatic load(input int a0, input int b0, input int step_a, input int step_b, input int cnt,
                      input bit with_eot);
    qa.delete(); qb.delete(); cap.delete(); exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      qa.push_back(33'(a0 + i*step_a));
      qb.push_back(33'(b0 + i*step_b));
    end
    if (with_eot) begin
      qa.push_back(EOT33);
      qb.push_back(EOT33);
    end
  endtask

  initial begin
    int seen;
    ap_rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0; n_a = '0; n_b = '0;
    aif.in_dout = '0; aif.in_empty_n = '0; aif.out_full_n = 1'b1;
    bif.in_dout = '0; bif.in_empty_n = '0; bif.out_full_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    #2;
    check("rst idle", 64'(a_idle), 64'd1);
    check("rst done", 64'(a_done), 64'd0);
    check("rst out_write", 64'(aif.out_write), 64'd0);
    check("rst out_din", 64'(aif.out_din), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #2;
    check("post-rst idle", 64'(a_idle), 64'd1);
    check("post-rst in_read", 64'(aif.in_read), 64'd0);
    check("post-rst elem_count", a_elem, 64'd0);
    check("post-rst err", {62'd0, a_err_eot, a_err_len}, 64'd0);

    // Basic run: a=0..4, b=1..5.
    load(0, 1, 1, 1, 5, 1'b1);
    exp_q = '{33'd1, 33'd3, 33'd5, 33'd7, 33'd9, EOT33};
    start_a(64'd5);
    wait_done_a("basic");
    check_cap("basic");
    check("basic elem_count", a_elem, 64'd5);
    check("basic err_eot", 64'(a_err_eot), 64'd0);
    check("basic err_len", 64'(a_err_len), 64'd0);

    // Downstream stalled: four beats fill the buffer, then nothing is read.
    aif.out_full_n = 1'b0;
    load(10, 1, 10, 1, 6, 1'b1);
    exp_q = '{33'd11, 33'd22, 33'd33, 33'd44, 33'd55, 33'd66, EOT33};
    start_a(64'd6);
    repeat (10) @(posedge ap_clk);
    #2;
    check("stall qa left @10", 64'(qa.size()), 64'd3);
    repeat (10) @(posedge ap_clk);
    #2;
    check("stall qa left @20", 64'(qa.size()), 64'd3);
    check("stall qb left @20", 64'(qb.size()), 64'd3);
    check("stall no output", 64'(cap.size()), 64'd0);
    check("stall in_read", 64'(aif.in_read), 64'd0);
    aif.out_full_n = 1'b1;
    wait_done_a("stall");
    check_cap("stall");
    check("stall elem_count", a_elem, 64'd6);
    check("stall err_len", 64'(a_err_len), 64'd0);

    // Lane 1 closes two beats early.
    qa.delete(); qb.delete(); cap.delete();
    qa = '{33'd1, 33'd2, 33'd3, EOT33};
    qb = '{33'd10, EOT33};
    exp_q = '{33'd11, EOT33};
    start_a(64'd3);
    wait_done_a("early eot");
    check_cap("early eot");
    check("early eot elem_count", a_elem, 64'd1);
    check("early eot err_eot", 64'(a_err_eot), 64'd1);
    check("early eot err_len", 64'(a_err_len), 64'd1);

    // One beat more than announced; a fresh start clears the sticky flags.
    load(0, 0, 1, 1, 6, 1'b1);
    exp_q = '{33'd0, 33'd2, 33'd4, 33'd6, 33'd8, 33'd10, EOT33};
    start_a(64'd5);
    wait_done_a("overlong");
    check_cap("overlong");
    check("overlong elem_count", a_elem, 64'd6);
    check("overlong err_eot", 64'(a_err_eot), 64'd0);
    check("overlong err_len", 64'(a_err_len), 64'd1);

    // Reset in the middle of a run, then a clean run.
    load(1, 1, 1, 1, 8, 1'b0);
    start_a(64'd8);
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(posedge ap_clk); #2;
      if (cap.size() >= 2) seen = 1;
    end
    check("midrun two words out", 64'(seen), 64'd1);
    ap_rst_n = 1'b0;
    #1;
    check("midrun rst idle", 64'(a_idle), 64'd1);
    check("midrun rst out_write", 64'(aif.out_write), 64'd0);
    check("midrun rst in_read", 64'(aif.in_read), 64'd0);
    check("midrun rst elem_count", a_elem, 64'd0);
    check("midrun rst done", 64'(a_done), 64'd0);
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    qa.delete(); qb.delete(); cap.delete();
    qa = '{33'd5, 33'd6, EOT33};
    qb = '{33'd7, 33'd8, EOT33};
    exp_q = '{33'd12, 33'd14, EOT33};
    start_a(64'd2);
    wait_done_a("after rst");
    check_cap("after rst");
    check("after rst elem_count", a_elem, 64'd2);
    check("after rst errs", {62'd0, a_err_eot, a_err_len}, 64'd0);

    // 4 lanes x 8 bits: 200+100+0+0 saturates to 255 or wraps to 44.
    @(posedge ap_clk); #2;
    bif.in_dout = {9'd0, 9'd0, 9'd100, 9'd200};
    bif.in_empty_n = 4'hF;
    n_b = 64'd1;
    b_start = 1'b1;
    @(posedge ap_clk); #2;
    b_start = 1'b0;
    check("sat in_read", 64'(bif.in_read), 64'hF);
    check("wrap in_read", 64'(cif.in_read), 64'hF);
    @(posedge ap_clk); #2;
    bif.in_empty_n = 4'h0;
    check("sat out_write", 64'(bif.out_write), 64'd1);
    check("sat sum", 64'(bif.out_din), 64'h0FF);
    check("wrap sum", 64'(cif.out_din), 64'h02C);
    bif.in_dout = {4{9'h100}};
    bif.in_empty_n = 4'hF;
    @(posedge ap_clk); #2;
    bif.in_empty_n = 4'h0;
    check("sat close token", 64'(bif.out_din), 64'h100);
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(posedge ap_clk); #2;
      if (b_done === 1'b1) seen = 1;
    end
    check("sat done seen", 64'(seen), 64'd1);
    check("sat elem_count", b_elem, 64'd1);
    check("sat errs", {62'd0, b_err_eot, b_err_len}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
